axi_sram_slave: RTL and testbench

- AXI4 responder (slave) modelling on-chip SRAM behind the Xbar SoC port. Answers read/write transactions issued by the core's AXI arbiter.
- Supports FIXED/INCR read bursts up to 256 beats, single-beat writes with byte strobes, and a configurable read latency.
- Echoes transaction IDs so the arbiter can route R data to IFU or LSU.

---
 rtl/axi_sram_slave_pkg.sv | 28 ++
 rtl/axi_sram_slave_if.sv | 53 +++++
 rtl/axi_sram_slave_mem.sv | 31 +++
 rtl/axi_sram_slave.sv | 200 ++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI constants and FSM encoding for the on-chip SRAM responder.
// The burst, response and ID encodings match the ones the core's AXI arbiter uses.
package axi_sram_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam int ID_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_DATA = 3'd3,
    ST_WR_RESP = 3'd4
  } state_t;

  // WRAP and the reserved encoding are answered with SLVERR on every beat.
  function automatic logic burst_supported(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI4 channel bundle between the Xbar SoC port (master) and the SRAM responder (slave).
interface axi_sram_slave_if
  import axi_sram_slave_pkg::*;
#(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
);
  logic [ADDR_LEN-1:0]   araddr;
  logic                  arvalid;
  logic                  arready;
  logic [ID_W-1:0]       arid;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [DATA_LEN-1:0]   rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  logic                  rlast;
  logic [ID_W-1:0]       rid;
  logic [ADDR_LEN-1:0]   awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [ID_W-1:0]       awid;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic [DATA_LEN-1:0]   wdata;
  logic [DATA_LEN/8-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic                  wlast;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ID_W-1:0]       bid;

  modport slave (
    input  araddr, arvalid, arid, arlen, arsize, arburst, rready,
    input  awaddr, awvalid, awid, awlen, awsize, awburst,
    input  wdata, wstrb, wvalid, wlast, bready,
    output arready, rdata, rresp, rvalid, rlast, rid,
    output awready, wready, bresp, bvalid, bid
  );

  modport master (
    output araddr, arvalid, arid, arlen, arsize, arburst, rready,
    output awaddr, awvalid, awid, awlen, awsize, awburst,
    output wdata, wstrb, wvalid, wlast, bready,
    input  arready, rdata, rresp, rvalid, rlast, rid,
    input  awready, wready, bresp, bvalid, bid
  );
endinterface

// File: rtl/axi_sram_slave_mem.sv
// SRAM word array: combinational read port, synchronous byte-strobed write port.
module axi_sram_slave_mem
  import axi_sram_slave_pkg::*;
#(
  parameter int DATA_LEN  = 32,
  parameter int MEM_WORDS = 1024,
  parameter int IDX_W     = 10
) (
  input  logic                  i_clock,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_waddr,
  input  logic [DATA_LEN-1:0]   i_wdata,
  input  logic [DATA_LEN/8-1:0] i_wstrb,
  input  logic [IDX_W-1:0]      i_raddr,
  output logic [DATA_LEN-1:0]   o_rdata
);
  logic [DATA_LEN-1:0] r_mem [MEM_WORDS];

  // Only the strobed byte lanes of the addressed word are updated.
  always_ff @(posedge i_clock) begin
    if (i_we) begin
      for (int i = 0; i < DATA_LEN / 8; i++) begin
        if (i_wstrb[i]) begin
          r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 responder fronting on-chip SRAM: FIXED/INCR read bursts with fixed latency,
// single-beat strobed writes, per-beat address decode and echoed IDs.
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int                  ADDR_LEN  = 32,
  parameter int                  DATA_LEN  = 32,
  parameter logic [ADDR_LEN-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                  MEM_WORDS = 1024,
  parameter int                  RD_LAT    = 2
) (
  input  logic               clock,
  input  logic               reset,
  axi_sram_slave_if.slave    bus
);
  localparam int                  IDX_W      = $clog2(MEM_WORDS);
  localparam int                  LAT_W      = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_LEN-1:0] SPAN       = ADDR_LEN'(4 * MEM_WORDS);
  localparam logic [ADDR_LEN-1:0] BEAT_BYTES = ADDR_LEN'(4);

  state_t                r_state;
  logic [ADDR_LEN-1:0]   r_raddr;
  logic [ADDR_LEN-1:0]   r_waddr;
  logic [ID_W-1:0]       r_arid;
  logic [ID_W-1:0]       r_awid;
  logic [7:0]            r_arlen;
  logic [7:0]            r_awlen;
  logic [1:0]            r_arburst;
  logic [7:0]            r_beat;
  logic [LAT_W-1:0]      r_lat_cnt;
  logic [DATA_LEN-1:0]   r_rdata;
  logic [1:0]            r_rresp;
  logic                  r_rvalid;
  logic                  r_rlast;
  logic [ID_W-1:0]       r_rid;
  logic [1:0]            r_bresp;
  logic                  r_bvalid;
  logic [ID_W-1:0]       r_bid;

  logic [ADDR_LEN-1:0]   w_beat_addr;
  logic [ADDR_LEN-1:0]   w_rd_off;
  logic [ADDR_LEN-1:0]   w_wr_off;
  logic                  w_rd_in_range;
  logic                  w_wr_in_range;
  logic                  w_we;
  logic [DATA_LEN-1:0]   w_mem_rdata;
  logic [DATA_LEN-1:0]   w_beat_data;
  logic [1:0]            w_beat_resp;
  logic                  w_unused;

  // While streaming, the read port already looks at the following beat so it can be
  // loaded on the handshake without a bubble.
  assign w_beat_addr   = ((r_state == ST_RD_DATA) && (r_arburst == BURST_INCR)) ?
                         (r_raddr + BEAT_BYTES) : r_raddr;
  assign w_rd_off      = w_beat_addr - BASE_ADDR;
  assign w_wr_off      = r_waddr - BASE_ADDR;
  assign w_rd_in_range = (w_beat_addr >= BASE_ADDR) && (w_rd_off < SPAN);
  assign w_wr_in_range = (r_waddr >= BASE_ADDR) && (w_wr_off < SPAN);

  assign w_we = (r_state == ST_WR_DATA) && bus.wvalid && !reset &&
                (r_awlen == 8'd0) && w_wr_in_range;

  assign bus.arready = (r_state == ST_IDLE) && !reset && !bus.awvalid;
  assign bus.awready = (r_state == ST_IDLE) && !reset;
  assign bus.wready  = (r_state == ST_WR_DATA);
  assign bus.rdata   = r_rdata;
  assign bus.rresp   = r_rresp;
  assign bus.rvalid  = r_rvalid;
  assign bus.rlast   = r_rlast;
  assign bus.rid     = r_rid;
  assign bus.bresp   = r_bresp;
  assign bus.bvalid  = r_bvalid;
  assign bus.bid     = r_bid;

  assign w_unused = ^{bus.arsize, bus.awsize, bus.awburst,
                      w_rd_off[1:0], w_rd_off[ADDR_LEN-1:IDX_W+2],
                      w_wr_off[1:0], w_wr_off[ADDR_LEN-1:IDX_W+2]};

  axi_sram_slave_mem #(
    .DATA_LEN  (DATA_LEN),
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IDX_W)
  ) u_mem (
    .i_clock (clock),
    .i_we    (w_we),
    .i_waddr (w_wr_off[IDX_W+1:2]),
    .i_wdata (bus.wdata),
    .i_wstrb (bus.wstrb),
    .i_raddr (w_rd_off[IDX_W+1:2]),
    .o_rdata (w_mem_rdata)
  );

  // Response and data of the beat addressed by w_beat_addr.
  always_comb begin
    w_beat_resp = RESP_OKAY;
    w_beat_data = '0;
    if (!burst_supported(r_arburst)) begin
      w_beat_resp = RESP_SLVERR;
    end else if (!w_rd_in_range) begin
      w_beat_resp = RESP_DECERR;
    end else begin
      w_beat_data = w_mem_rdata;
    end
  end

  // Transaction FSM with registered R and B channel outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_raddr   <= '0;
      r_waddr   <= '0;
      r_arid    <= '0;
      r_awid    <= '0;
      r_arlen   <= 8'd0;
      r_awlen   <= 8'd0;
      r_arburst <= BURST_FIXED;
      r_beat    <= 8'd0;
      r_lat_cnt <= '0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_bresp   <= RESP_OKAY;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.awvalid) begin
            r_waddr <= bus.awaddr;
            r_awid  <= bus.awid;
            r_awlen <= bus.awlen;
            r_state <= ST_WR_DATA;
          end else if (bus.arvalid) begin
            r_raddr   <= bus.araddr;
            r_arid    <= bus.arid;
            r_arlen   <= bus.arlen;
            r_arburst <= bus.arburst;
            r_beat    <= 8'd0;
            r_lat_cnt <= LAT_W'(RD_LAT - 1);
            r_state   <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (r_lat_cnt == '0) begin
            r_rdata  <= w_beat_data;
            r_rresp  <= w_beat_resp;
            r_rid    <= r_arid;
            r_rlast  <= (r_arlen == 8'd0);
            r_rvalid <= 1'b1;
            r_state  <= ST_RD_DATA;
          end else begin
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
          end
        end
        ST_RD_DATA: begin
          if (bus.rready) begin
            if (r_beat == r_arlen) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_state  <= ST_IDLE;
            end else begin
              r_beat  <= r_beat + 8'd1;
              r_raddr <= w_beat_addr;
              r_rdata <= w_beat_data;
              r_rresp <= w_beat_resp;
              r_rlast <= ((r_beat + 8'd1) == r_arlen);
            end
          end
        end
        ST_WR_DATA: begin
          // Multi-beat writes are drained up to wlast but never committed.
          if (bus.wvalid) begin
            if (r_awlen == 8'd0) begin
              r_bresp  <= w_wr_in_range ? RESP_OKAY : RESP_DECERR;
              r_bid    <= r_awid;
              r_bvalid <= 1'b1;
              r_state  <= ST_WR_RESP;
            end else if (bus.wlast) begin
              r_bresp  <= RESP_SLVERR;
              r_bid    <= r_awid;
              r_bvalid <= 1'b1;
              r_state  <= ST_WR_RESP;
            end
          end
        end
        ST_WR_RESP: begin
          if (bus.bready) begin
            r_bvalid <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: a vector table of AXI transactions with an
// R/B scoreboard, plus hand-written sequences for the AW/AR race and mid-burst reset.
`timescale 1ns/1ps
module tb_axi_sram_slave;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  axi_sram_slave_if #(.ADDR_LEN(32), .DATA_LEN(32)) bus ();

  axi_sram_slave #(
    .ADDR_LEN  (32),
    .DATA_LEN  (32),
    .BASE_ADDR (32'h8000_0000),
    .MEM_WORDS (1024),
    .RD_LAT    (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rbeat_t;

  typedef struct {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdy_pat;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
  } vec_t;

  rbeat_t      rq[$];
  bexp_t       bq[$];
  logic [31:0] model [0:1023];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic rbeat_t model_beat(input logic [31:0] addr, input logic [1:0] burst,
                                        input logic [3:0] id, input bit last);
    rbeat_t      b;
    logic [31:0] off;
    off    = addr - 32'h8000_0000;
    b.id   = id;
    b.last = last;
    b.data = 32'h0;
    if (burst == 2'b10 || burst == 2'b11) begin
      b.resp = 2'b10;
    end else if (addr < 32'h8000_0000 || addr > 32'h8000_0FFF) begin
      b.resp = 2'b11;
    end else begin
      b.resp = 2'b00;
      b.data = model[off[11:2]];
    end
    return b;
  endfunction

  task automatic idle_bus();
    bus.araddr = 32'h0; bus.arvalid = 1'b0; bus.arid = 4'h0; bus.arlen = 8'h0;
    bus.arsize = 3'd2; bus.arburst = 2'b01; bus.rready = 1'b0;
    bus.awaddr = 32'h0; bus.awvalid = 1'b0; bus.awid = 4'h0; bus.awlen = 8'h0;
    bus.awsize = 3'd2; bus.awburst = 2'b01;
    bus.wdata = 32'h0; bus.wstrb = 4'h0; bus.wvalid = 1'b0; bus.wlast = 1'b0;
    bus.bready = 1'b0;
  endtask

  task automatic send_aw(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    int n = 0;
    bus.awaddr = addr; bus.awid = id; bus.awlen = len; bus.awvalid = 1'b1;
    #1;
    while (bus.awready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("aw_accept", (n < 50) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clock);
    bus.awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst);
    int n = 0;
    bus.araddr = addr; bus.arid = id; bus.arlen = len; bus.arburst = burst; bus.arvalid = 1'b1;
    #1;
    while (bus.arready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("ar_accept", (n < 50) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clock);
    bus.arvalid = 1'b0;
  endtask

  task automatic push_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst);
    logic [31:0] a = addr;
    for (int b = 0; b <= int'(len); b++) begin
      rq.push_back(model_beat(a, burst, id, (b == int'(len))));
      if (burst == 2'b01) a = a + 32'd4;
    end
  endtask

  // Entered at the negedge after the AR handshake; checks latency and every beat.
  task automatic collect_read(input logic [31:0] pat, output logic [31:0] first_data,
                              output logic [1:0] first_resp);
    int     lat = 0;
    int     k = 0;
    bit     got_first = 1'b0;
    rbeat_t e;
    first_data = 32'hxxxx_xxxx;
    first_resp = 2'bxx;
    while (bus.rvalid !== 1'b1 && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    check("r_latency", 32'(lat), 32'd2);
    while (rq.size() > 0 && k < 600) begin
      e = rq[0];
      bus.rready = pat[k % 32];
      check("r_valid", 32'(bus.rvalid), 32'd1);
      check("r_data", bus.rdata, e.data);
      check("r_resp", 32'(bus.rresp), 32'(e.resp));
      check("r_last", 32'(bus.rlast), 32'(e.last));
      check("r_id", 32'(bus.rid), 32'(e.id));
      if (bus.rready) begin
        if (!got_first) begin
          first_data = bus.rdata;
          first_resp = bus.rresp;
          got_first  = 1'b1;
        end
        e = rq.pop_front();
      end
      k++;
      @(negedge clock);
    end
    bus.rready = 1'b0;
    check("r_done", 32'(bus.rvalid), 32'd0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] exp_resp);
    bexp_t       eb;
    logic [31:0] off;
    eb.resp = exp_resp;
    eb.id   = id;
    bq.push_back(eb);
    send_aw(addr, id, len);
    for (int i = 0; i <= int'(len); i++) begin
      int n = 0;
      bus.wdata = data + 32'(i); bus.wstrb = strb; bus.wlast = (i == int'(len)); bus.wvalid = 1'b1;
      #1;
      while (bus.wready !== 1'b1 && n < 50) begin
        @(negedge clock);
        n++;
      end
      check("w_accept", (n < 50) ? 32'd1 : 32'd0, 32'd1);
      @(negedge clock);
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    if (exp_resp == 2'b00 && len == 8'd0) begin
      off = addr - 32'h8000_0000;
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model[off[11:2]][8*b +: 8] = data[8*b +: 8];
      end
    end
    check("b_latency", 32'(bus.bvalid), 32'd1);
    @(negedge clock);
    check("b_held", 32'(bus.bvalid), 32'd1);
    eb = bq.pop_front();
    check("b_resp", 32'(bus.bresp), 32'(eb.resp));
    check("b_id", 32'(bus.bid), 32'(eb.id));
    bus.bready = 1'b1;
    @(negedge clock);
    bus.bready = 1'b0;
    check("b_drop", 32'(bus.bvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  localparam int NV = 21;
  vec_t        vecs [NV];
  logic [31:0] d;
  logic [1:0]  r;

  initial begin
    // wr addr id len burst wdata wstrb rdy_pat exp_resp exp_data
    vecs[0]  = '{1'b1, 32'h8000_0010, 4'h1, 8'd0, 2'b01, 32'hDEAD_BEEF, 4'hF, 32'hFFFF_FFFF, 2'b00, 32'h0};
    vecs[1]  = '{1'b0, 32'h8000_0010, 4'h2, 8'd0, 2'b01, 32'h0, 4'h0, 32'hFFFF_FFFF, 2'b00, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h8000_0010, 4'h3, 8'd0, 2'b01, 32'h0000_AA00, 4'b0010, 32'hFFFF_FFFF, 2'b00, 32'h0};
    vecs[3]  = '{1'b0, 32'h8000_0010, 4'h4, 8'd0, 2'b01, 32'h0, 4'h0, 32'hFFFF_FFFF, 2'b00, 32'hDEAD_AAEF};
    vecs[4]  = '{1'b1, 32'h8000_0000, 4'h5, 8'd0, 2'b01, 32'h1111_1111, 4'hF, 32'hFFFF_FFFF, 2'b00, 32'h0};
    vecs[5]  = '{1'b1, 32'h8000_0004, 4'h6, 8'd0, 2'b01, 32'h2222_2222, 4'hF, 32'hFFFF_FFFF, 2'b00, 32'h0};
    vecs[6]  = '{1'b1, 32'h8000_0008, 4'h7, 8'd0, 2'b01, 32'h3333_3333, 4'hF, 32'hFFFF_FFFF, 2'b00, 32'h0};
    vecs[7]  = '{1'b1, 32'h8000_000C, 4'h8, 8'd0, 2'b01, 32'h4444_4444, 4'hF, 32'hFFFF_FFFF, 2'b00, 32'h0};
    vecs[8]  = '{1'b0, 32'h8000_0000, 4'h9, 8'd3, 2'b01, 32'h0, 4'h0, 32'hFFFF_FFFD, 2'b00, 32'h1111_1111};
    vecs[9]  = '{1'b1, 32'h8000_0FF8, 4'hA, 8'd0, 2'b01, 32'h5555_5555, 4'hF, 32'hFFFF_FFFF, 2'b00, 32'h0};
    vecs[10] = '{1'b1, 32'h8000_0FFC, 4'hA, 8'd0, 2'b01, 32'h6666_6666, 4'hF, 32'hFFFF_FFFF, 2'b00, 32'h0};
    vecs[11] = '{1'b0, 32'h8000_0FF8, 4'hB, 8'd3, 2'b01, 32'h0, 4'h0, 32'hFFFF_FFFF, 2'b00, 32'h5555_5555};
    vecs[12] = '{1'b0, 32'h8000_0000, 4'hC, 8'd1, 2'b10, 32'h0, 4'h0, 32'hFFFF_FFFF, 2'b10, 32'h0};
    vecs[13] = '{1'b1, 32'h8000_0010, 4'hD, 8'd1, 2'b01, 32'h1234_5678, 4'hF, 32'hFFFF_FFFF, 2'b10, 32'h0};
    vecs[14] = '{1'b1, 32'h0000_0010, 4'h3, 8'd0, 2'b01, 32'hBADB_AD00, 4'hF, 32'hFFFF_FFFF, 2'b11, 32'h0};
    vecs[15] = '{1'b1, 32'h8000_1000, 4'h6, 8'd0, 2'b01, 32'hBADB_AD01, 4'hF, 32'hFFFF_FFFF, 2'b11, 32'h0};
    vecs[16] = '{1'b0, 32'h8000_0010, 4'h1, 8'd0, 2'b01, 32'h0, 4'h0, 32'hFFFF_FFFF, 2'b00, 32'hDEAD_AAEF};
    vecs[17] = '{1'b0, 32'h8000_0000, 4'h2, 8'd0, 2'b01, 32'h0, 4'h0, 32'hFFFF_FFFF, 2'b00, 32'h1111_1111};
    vecs[18] = '{1'b0, 32'h7FFF_FFFC, 4'h7, 8'd0, 2'b01, 32'h0, 4'h0, 32'hFFFF_FFFF, 2'b11, 32'h0};
    vecs[19] = '{1'b0, 32'h8000_0004, 4'hF, 8'd2, 2'b00, 32'h0, 4'h0, 32'hFFFF_FFF5, 2'b00, 32'h2222_2222};
    vecs[20] = '{1'b0, 32'h8000_0FFC, 4'hE, 8'd0, 2'b01, 32'h0, 4'h0, 32'hFFFF_FFFF, 2'b00, 32'h6666_6666};

    idle_bus();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_awready", 32'(bus.awready), 32'd0);
    check("reset_arready", 32'(bus.arready), 32'd0);
    reset = 1'b0;
    #1;
    check("idle_awready", 32'(bus.awready), 32'd1);
    check("idle_arready", 32'(bus.arready), 32'd1);
    check("reset_valids", {28'h0, bus.rvalid, bus.bvalid, bus.wready, bus.rlast}, 32'h0);
    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_ids_resps", {20'h0, bus.rid, bus.bid, bus.rresp, bus.bresp}, 32'h0);
    @(negedge clock);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].id, vecs[i].len, vecs[i].wdata, vecs[i].wstrb,
                 vecs[i].exp_resp);
      end else begin
        push_read(vecs[i].addr, vecs[i].id, vecs[i].len, vecs[i].burst);
        send_ar(vecs[i].addr, vecs[i].id, vecs[i].len, vecs[i].burst);
        collect_read(vecs[i].rdy_pat, d, r);
        check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
        check($sformatf("vec%0d_resp", i), 32'(r), 32'(vecs[i].exp_resp));
      end
    end

    // AW and AR together: the write wins, W offered with AW is held off one cycle.
    bus.awaddr = 32'h8000_0020; bus.awid = 4'hE; bus.awlen = 8'd0; bus.awvalid = 1'b1;
    bus.araddr = 32'h8000_0020; bus.arid = 4'h5; bus.arlen = 8'd0; bus.arburst = 2'b01;
    bus.arvalid = 1'b1;
    bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
    #1;
    check("race_arready", 32'(bus.arready), 32'd0);
    check("race_awready", 32'(bus.awready), 32'd1);
    check("race_wready_idle", 32'(bus.wready), 32'd0);
    @(negedge clock);
    bus.awvalid = 1'b0;
    #1;
    check("race_wready_data", 32'(bus.wready), 32'd1);
    check("race_arready_wr", 32'(bus.arready), 32'd0);
    @(negedge clock);
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    model[8] = 32'hCAFE_F00D;
    check("race_bvalid", 32'(bus.bvalid), 32'd1);
    check("race_bid", 32'(bus.bid), 32'hE);
    check("race_bresp", 32'(bus.bresp), 32'd0);
    check("race_arready_resp", 32'(bus.arready), 32'd0);
    bus.bready = 1'b1;
    @(negedge clock);
    bus.bready = 1'b0;
    check("race_ar_first_idle", 32'(bus.arready), 32'd1);
    push_read(32'h8000_0020, 4'h5, 8'd0, 2'b01);
    @(negedge clock);
    bus.arvalid = 1'b0;
    collect_read(32'hFFFF_FFFF, d, r);
    check("race_read_data", d, 32'hCAFE_F00D);

    // Reset in the middle of a read burst drops rvalid on the next cycle.
    send_ar(32'h8000_0000, 4'h1, 8'd3, 2'b01);
    begin
      int n = 0;
      while (bus.rvalid !== 1'b1 && n < 50) begin
        @(negedge clock);
        n++;
      end
    end
    check("midrd_rvalid_up", 32'(bus.rvalid), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrd_rvalid_drop", 32'(bus.rvalid), 32'd0);
    check("midrd_rlast_drop", 32'(bus.rlast), 32'd0);

    // Reset in WR_DATA with a W beat present must not write the SRAM.
    send_aw(32'h8000_0004, 4'h2, 8'd0);
    bus.wdata = 32'hBAD0_BAD0; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check("midwr_bvalid", 32'(bus.bvalid), 32'd0);
    push_read(32'h8000_0004, 4'h3, 8'd0, 2'b01);
    send_ar(32'h8000_0004, 4'h3, 8'd0, 2'b01);
    collect_read(32'hFFFF_FFFF, d, r);
    check("midwr_mem_kept", d, 32'h2222_2222);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
